// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_EXC    = 2'd3
  } redirect_src_t;

  // Sequential successor of a PC; wraps naturally at 2^32.
  function automatic logic [31:0] pc_increment(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Next-PC source selection: exception > jump > branch, plus the +4 successor.
module next_pc_select
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        exception,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);

  redirect_src_t src;
  logic [31:0]   branch_sum;

  // Priority-encode the redirect source and form its target address.
  always_comb begin
    branch_sum = branch_base + branch_offset;
    seq_pc     = pc_increment(pc);
    src        = SRC_NONE;
    target     = seq_pc;
    if (exception) begin
      src = SRC_EXC;
    end else if (jump_valid) begin
      src = SRC_JUMP;
    end else if (branch_taken) begin
      src = SRC_BRANCH;
    end else begin
      src = SRC_NONE;
    end
    case (src)
      SRC_EXC:    target = EXC_VECTOR;
      SRC_JUMP:   target = jump_target;
      SRC_BRANCH: target = branch_sum;
      SRC_NONE:   target = seq_pc;
      default:    target = seq_pc;
    endcase
    redirect = (src != SRC_NONE);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Stall- and redirect-aware fetch controller: owns the PC, runs the imem
// req/ack handshake and presents fetched words to decode via valid/ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        exception,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] retired_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         pending_valid, pending_valid_next;
  logic [31:0]  pending_target, pending_target_next;
  logic         halt_pending;
  logic         halt_now;
  logic         load_instr;
  logic         retire;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  seq_pc;

  next_pc_select #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .pc            (pc),
    .exception     (exception),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .redirect      (redirect),
    .target        (target),
    .seq_pc        (seq_pc)
  );

  assign halt_now  = halt_pending | halt;
  assign imem_addr = pc;

  // Next-state, next-PC and pending-redirect decisions.
  always_comb begin
    state_next          = state;
    pc_next             = pc;
    pending_valid_next  = pending_valid;
    pending_target_next = pending_target;
    load_instr          = 1'b0;
    retire              = 1'b0;
    case (state)
      ST_IDLE: begin
        if (redirect) begin
          pc_next = target;
        end else begin
          pc_next = pc;
        end
        if (halt_now) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          // The request completes; any redirect seen during it discards the word.
          pending_valid_next = 1'b0;
          if (redirect) begin
            pc_next    = target;
            state_next = ST_FETCH;
          end else if (pending_valid) begin
            pc_next    = pending_target;
            state_next = ST_FETCH;
          end else begin
            load_instr = 1'b1;
            pc_next    = seq_pc;
            state_next = ST_HOLD;
          end
        end else begin
          // Request stays stable; remember the newest redirect for the ack.
          if (redirect) begin
            pending_valid_next  = 1'b1;
            pending_target_next = target;
          end else begin
            pending_valid_next  = pending_valid;
            pending_target_next = pending_target;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = halt_now ? ST_HALTED : ST_FETCH;
        end else if (instr_ready) begin
          retire     = 1'b1;
          state_next = halt_now ? ST_HALTED : ST_FETCH;
        end else begin
          state_next = ST_HOLD;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, PC, held instruction and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      pending_valid  <= 1'b0;
      pending_target <= 32'h0000_0000;
      halt_pending   <= 1'b0;
      instr          <= 32'h0000_0000;
      instr_pc       <= 32'h0000_0000;
      retired_count  <= 32'h0000_0000;
      imem_req       <= 1'b0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pending_valid  <= pending_valid_next;
      pending_target <= pending_target_next;
      halt_pending   <= halt_pending | halt;
      if (load_instr) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (retire) begin
        retired_count <= retired_count + 32'd1;
      end
      imem_req    <= (state_next == ST_FETCH);
      instr_valid <= (state_next == ST_HOLD);
      halted      <= (state_next == ST_HALTED);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected
// retirements; a forked monitor pops and compares on each decode handshake.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } sb_item_t;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [31:0] branch_offset;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        exception;
  logic        halt;
  logic        halted;
  logic [31:0] retired_count;

  logic        ack_en;
  int          checks;
  int          errors;
  sb_item_t    exp_q[$];

  fetch_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .exception     (exception),
    .halt          (halt),
    .halted        (halted),
    .retired_count (retired_count)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock; the memory model answers the request seen after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    imem_ack   = ack_en & imem_req;
    imem_rdata = imem_addr ^ 32'h5A5A_0000;
  endtask

  task automatic push(input logic [31:0] word, input logic [31:0] pc);
    sb_item_t it;
    it.word = word;
    it.pc   = pc;
    exp_q.push_back(it);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ack_en       = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump_valid   = 1'b0;
    exception    = 1'b0;
    halt         = 1'b0;
    step();
    step();
    check("rst_req",     {31'd0, imem_req},    32'd0);
    check("rst_addr",    imem_addr,            32'h0000_0000);
    check("rst_valid",   {31'd0, instr_valid}, 32'd0);
    check("rst_instr",   instr,                32'h0000_0000);
    check("rst_instrpc", instr_pc,             32'h0000_0000);
    check("rst_halted",  {31'd0, halted},      32'd0);
    check("rst_retired", retired_count,        32'd0);
    reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    ack_en        = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0000_0000;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_base   = 32'h0000_0000;
    branch_offset = 32'h0000_0000;
    jump_valid    = 1'b0;
    jump_target   = 32'h0000_0000;
    exception     = 1'b0;
    halt          = 1'b0;

    // Monitor: every decode handshake must match the head of the scoreboard.
    fork
      begin : monitor
        sb_item_t e;
        forever begin
          @(negedge clock);
          if (!reset && instr_valid && instr_ready && !branch_taken && !jump_valid && !exception) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected_retire actual_pc=%h expected=none", instr_pc);
            end else begin
              e = exp_q.pop_front();
              check("sb_instr", instr, e.word);
              check("sb_instr_pc", instr_pc, e.pc);
            end
          end
        end
      end
    join_none

    // Streaming: ack always, ready always -> one instruction every 2 cycles.
    do_reset();
    check("idle_no_req", {31'd0, imem_req}, 32'd0);
    ack_en      = 1'b1;
    instr_ready = 1'b1;
    push(32'h5A5A_0000, 32'h0000_0000);
    push(32'h5A5A_0004, 32'h0000_0004);
    push(32'h5A5A_0008, 32'h0000_0008);
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("stream_addr0", imem_addr, 32'h0000_0000);
    step();
    check("stream_valid", {31'd0, instr_valid}, 32'd1);
    step();
    check("stream_addr4", imem_addr, 32'h0000_0004);
    step();
    step();
    check("stream_addr8", imem_addr, 32'h0000_0008);
    ack_en = 1'b0;
    step();
    step();
    check("stream_retired3", retired_count, 32'd3);
    check("stream_addr12", imem_addr, 32'h0000_000C);

    // Stalled fetch: address stable, nothing presented, then DEAD_BEEF lands.
    do_reset();
    instr_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, 32'h0000_0000);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    push(32'hDEAD_BEEF, 32'h0000_0000);
    step();
    check("stall_instr", instr, 32'hDEAD_BEEF);
    check("stall_instr_pc", instr_pc, 32'h0000_0000);
    check("stall_hold_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    step();
    check("stall_retired1", retired_count, 32'd1);
    check("stall_next_addr", imem_addr, 32'h0000_0004);

    // Branch mid-fetch: word discarded, refetch at 0x10 + 0x20.
    branch_taken  = 1'b1;
    branch_base   = 32'h0000_0010;
    branch_offset = 32'h0000_0020;
    step();
    branch_taken = 1'b0;
    check("br_addr_stable", imem_addr, 32'h0000_0004);
    step();
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    step();
    check("br_req", {31'd0, imem_req}, 32'd1);
    check("br_addr", imem_addr, 32'h0000_0030);
    check("br_no_valid", {31'd0, instr_valid}, 32'd0);
    check("br_retired", retired_count, 32'd1);

    // Exception and jump together in HOLD: exception wins, held word dropped.
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h7777_0030;
    step();
    check("exc_hold_valid", {31'd0, instr_valid}, 32'd1);
    check("exc_hold_pc", instr_pc, 32'h0000_0030);
    exception   = 1'b1;
    jump_valid  = 1'b1;
    jump_target = 32'h0000_0400;
    instr_ready = 1'b1;
    step();
    exception  = 1'b0;
    jump_valid = 1'b0;
    check("exc_addr", imem_addr, 32'h0000_0080);
    check("exc_req", {31'd0, imem_req}, 32'd1);
    check("exc_valid", {31'd0, instr_valid}, 32'd0);
    check("exc_retired", retired_count, 32'd1);

    // Halt during FETCH: fetch completes, retires, then stops for good.
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_inflight_req", {31'd0, imem_req}, 32'd1);
    check("halt_not_yet", {31'd0, halted}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_0080;
    push(32'hCAFE_0080, 32'h0000_0080);
    step();
    check("halt_hold_valid", {31'd0, instr_valid}, 32'd1);
    step();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_retired", retired_count, 32'd2);
    check("halt_valid_low", {31'd0, instr_valid}, 32'd0);
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
      check("halt_sticky", {31'd0, halted}, 32'd1);
    end

    // PC wrap: jump to the top word, fetch it, next address is 0.
    do_reset();
    jump_valid  = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    jump_valid = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h1234_5678;
    instr_ready = 1'b1;
    push(32'h1234_5678, 32'hFFFF_FFFC);
    step();
    step();
    check("wrap_addr_zero", imem_addr, 32'h0000_0000);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_retired", retired_count, 32'd1);

    step();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
